// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
//   Runtime-programmable serial pattern detector. One bit of x is sampled per
//   enabled clock. z pulses for one cycle when the newest plen bits equal the
//   low plen bits of the loaded pattern. Overlapping and non-overlapping
//   detection are chosen per cycle with `overlap`.
//
//   Optional feature macro: SEQDET_MATCH_CNT_EN
//     When it is defined, a saturating match counter drives match_cnt.
//     When it is undefined, match_cnt is tied to zero and no counter exists.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   sample enable
//   x          in   serial data bit
//   overlap    in   1 = overlapping detection, 0 = restart after a match
//   cfg_load   in   strobe: latch cfg_pat / cfg_len (wins over en)
//   cfg_pat    in   pattern; bit [len-1] arrives first, bit [0] arrives last
//   cfg_len    in   pattern length (valid range 1..MAX_LEN)
//   z          out  registered one-cycle match pulse
//   cfg_err    out  active configuration has an invalid length
//   match_cnt  out  saturating match count (zero without the macro)
// ---------------------------------------------------------------------------
module seq_det_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = 8'b0000_0110,
  parameter int                 DEF_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               z,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_DEF_C = LEN_W'(DEF_LEN);
  localparam logic             ERR_DEF_C = (DEF_LEN == 0) || (DEF_LEN > MAX_LEN);

  // Mask selecting the low `len` bits of a MAX_LEN-wide vector. Built bit by
  // bit so that len == MAX_LEN needs no shift wider than the vector.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // A length is usable only inside 1..MAX_LEN.
  function automatic logic len_invalid(input logic [LEN_W-1:0] len);
    return (len == {LEN_W{1'b0}}) || (len > LEN_MAX_C);
  endfunction

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_plen;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_z;
  logic               r_err;

  logic [MAX_LEN-1:0] w_nh;
  logic [LEN_W-1:0]   w_nf;
  logic               w_hit;
  logic               w_run;

  logic [MAX_LEN-1:0] w_pat_n;
  logic [LEN_W-1:0]   w_plen_n;
  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic               w_z_n;
  logic               w_err_n;

  // Candidate history/fill if x were shifted in, and the match decision on it.
  always_comb begin
    w_nh  = {r_hist[MAX_LEN-2:0], x};
    if (r_fill >= LEN_MAX_C) begin
      w_nf = LEN_MAX_C;
    end else begin
      w_nf = r_fill + LEN_W'(1);
    end
    // Upper pattern bits beyond plen are masked away before comparing.
    w_hit = (w_nf >= r_plen) &&
            (((w_nh ^ r_pat) & len_mask(r_plen)) == {MAX_LEN{1'b0}});
    // A bit is really consumed only when no load, no error and enabled.
    w_run = !cfg_load && !r_err && en;
  end

  // Next-state selection in priority order: load, error, idle, run.
  always_comb begin
    w_pat_n  = r_pat;
    w_plen_n = r_plen;
    w_hist_n = r_hist;
    w_fill_n = r_fill;
    w_z_n    = 1'b0;
    w_err_n  = r_err;
    if (cfg_load) begin
      w_pat_n  = cfg_pat;
      w_plen_n = cfg_len;
      w_hist_n = {MAX_LEN{1'b0}};
      w_fill_n = {LEN_W{1'b0}};
      w_err_n  = len_invalid(cfg_len);
    end else if (r_err) begin
      // Locked out until a valid load; history is frozen.
      w_z_n = 1'b0;
    end else if (!en) begin
      w_z_n = 1'b0;
    end else if (w_hit) begin
      w_z_n = 1'b1;
      if (overlap) begin
        w_hist_n = w_nh;
        w_fill_n = w_nf;
      end else begin
        // Non-overlapping: the matched bits may not start another match.
        w_hist_n = {MAX_LEN{1'b0}};
        w_fill_n = {LEN_W{1'b0}};
      end
    end else begin
      w_hist_n = w_nh;
      w_fill_n = w_nf;
    end
  end

  // Configuration, history and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat  <= DEF_PAT;
      r_plen <= LEN_DEF_C;
      r_hist <= {MAX_LEN{1'b0}};
      r_fill <= {LEN_W{1'b0}};
      r_z    <= 1'b0;
      r_err  <= ERR_DEF_C;
    end else begin
      r_pat  <= w_pat_n;
      r_plen <= w_plen_n;
      r_hist <= w_hist_n;
      r_fill <= w_fill_n;
      r_z    <= w_z_n;
      r_err  <= w_err_n;
    end
  end

  assign z       = r_z;
  assign cfg_err = r_err;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_match_cnt;

  // Saturating match counter, cleared by every configuration load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_cnt <= {CNT_W{1'b0}};
    end else if (cfg_load) begin
      r_match_cnt <= {CNT_W{1'b0}};
    end else if (w_run && w_hit && (r_match_cnt != {CNT_W{1'b1}})) begin
      r_match_cnt <= r_match_cnt + CNT_W'(1);
    end else begin
      r_match_cnt <= r_match_cnt;
    end
  end

  assign match_cnt = r_match_cnt;
`else
  assign match_cnt = {CNT_W{1'b0}};

  // w_run only feeds the counter; fold it into a harmless unused sink.
  logic w_unused;
  assign w_unused = w_run;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_det_prog
//   Directed test-plan sequences followed by randomized traffic, all checked
//   against a queue-based reference model of the detector. Each applied cycle
//   compares z, cfg_err and match_cnt one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_seq_det_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst;
  logic               en;
  logic               x;
  logic               overlap;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               z;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  int n_vec;
  int n_err;

  // Reference model state: bits received since the last clear, oldest first.
  bit                 mq[$];
  logic [MAX_LEN-1:0] m_pat;
  int                 m_plen;
  bit                 m_err;
  int                 m_cnt;
  bit                 m_z;

  seq_det_prog #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .x        (x),
    .overlap  (overlap),
    .cfg_load (cfg_load),
    .cfg_pat  (cfg_pat),
    .cfg_len  (cfg_len),
    .z        (z),
    .cfg_err  (cfg_err),
    .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_cnt();
`ifdef SEQDET_MATCH_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pat  = 8'b0000_0110;
    m_plen = 4;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_z    = 1'b0;
  endtask

  // Apply one rising edge of the current inputs to the model.
  task automatic model_edge();
    bit hit;
    if (cfg_load) begin
      m_pat  = cfg_pat;
      m_plen = int'(cfg_len);
      m_err  = (m_plen == 0) || (m_plen > MAX_LEN);
      mq.delete();
      m_cnt  = 0;
      m_z    = 1'b0;
    end else if (m_err || !en) begin
      m_z = 1'b0;
    end else begin
      mq.push_back(x);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      hit = (mq.size() >= m_plen);
      // Newest received bit pairs with pattern bit 0, older ones upward.
      for (int k = 0; k < m_plen; k++) begin
        if (hit && (mq[mq.size() - 1 - k] != m_pat[k])) hit = 1'b0;
      end
      m_z = hit;
      if (hit) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!overlap) mq.delete();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".z"},   int'(z),         int'(m_z));
    chk({tag, ".err"}, int'(cfg_err),   int'(m_err));
    chk({tag, ".cnt"}, int'(match_cnt), exp_cnt());
  endtask

  task automatic step(input bit e, input bit b, input bit ov, input bit ld,
                      input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input string tag);
    @(negedge clk);
    en = e; x = b; overlap = ov; cfg_load = ld; cfg_pat = p; cfg_len = l;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic send(input bit b, input bit ov, input string tag);
    step(1'b1, b, ov, 1'b0, 8'h00, 4'd0, tag);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l);
    step(1'b0, 1'b0, 1'b0, 1'b1, p, l, "load");
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input bit ov,
                           input string tag);
    for (int i = n - 1; i >= 0; i--) send(bits[i], ov, tag);
  endtask

  initial begin
    logic [15:0] seq;
    n_vec = 0; n_err = 0;
    en = 1'b0; x = 1'b0; overlap = 1'b1; cfg_load = 1'b0;
    cfg_pat = 8'h00; cfg_len = 4'd0;
    rst = 1'b1;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk); rst = 1'b0;

    // Reset defaults: 0110 with length 4.
    seq = 16'b0110;
    send_bits(seq, 4, 1'b1, "defaults");
    chk("defaults.pulse", int'(z), 1);

    // Overlap vs non-overlap on 0110110.
    load(8'b0000_0110, 4'd4);
    seq = 16'b0110110;
    send_bits(seq, 7, 1'b1, "ovl1");
    load(8'b0000_0110, 4'd4);
    send_bits(seq, 7, 1'b0, "ovl0");

    // Full-length pattern.
    load(8'b1011_0011, 4'd8);
    seq = 16'b1011_0011;
    send_bits(seq, 8, 1'b1, "full");
    chk("full.pulse", int'(z), 1);

    // Invalid lengths block detection; a valid load clears the error.
    load(8'b0000_0001, 4'd0);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1, "len0");
    load(8'b0000_0001, 4'd9);
    chk("len9.err", int'(cfg_err), 1);
    for (int i = 0; i < 6; i++) send(1'b1, 1'b1, "len9");
    load(8'b0000_0101, 4'd3);
    chk("len3.err", int'(cfg_err), 0);
    seq = 16'b101;
    send_bits(seq, 3, 1'b1, "len3");

    // Enable gaps and load priority.
    load(8'b0000_0111, 4'd3);
    send(1'b1, 1'b1, "gap");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, "gap.idle");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, "gap.idle");
    send(1'b1, 1'b1, "gap");
    send(1'b1, 1'b1, "gap");
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0001, 4'd1, "ldprio");
    send(1'b1, 1'b1, "ldprio.next");

    // Single-bit pattern driven long enough to saturate the counter.
    load(8'b0000_0001, 4'd1);
    for (int i = 0; i < 260; i++) send(1'b1, i[0], "sat");

    // Asynchronous reset between edges while z is high.
    load(8'b0000_0001, 4'd1);
    send(1'b1, 1'b1, "arst.pre");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.z",   int'(z), 0);
    chk("arst.err", int'(cfg_err), 0);
    chk("arst.cnt", int'(match_cnt), 0);
    en = 1'b0; cfg_load = 1'b0;
    @(negedge clk); rst = 1'b0;

    // Randomized traffic with occasional loads and idle cycles.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, 1'b1,
             8'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 4)),
             "rnd.load");
      end else begin
        step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, 1'b0, 8'($urandom), 4'($urandom),
             "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
